// File: rtl/wb_queue.sv
// Register write-back queue: circular FIFO with hazard lookup.
// Define WBQ_FORWARD_EN to forward the youngest matching queued value on q_data.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_addr,
  input  logic [31:0]               in_data,
  input  logic                      drain_en,
  output logic                      write_reg,
  output logic [4:0]                w_addr,
  output logic [31:0]               w_data,
  input  logic [4:0]                q_addr,
  output logic                      q_pending,
  output logic [31:0]               q_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          push;
  logic          store;
  logic          pop;
  logic [AW-1:0] idx;

  assign empty     = (cnt == '0);
  assign in_ready  = rst && (cnt != FULL);
  assign push      = in_valid && in_ready;
  // Writes to x0 are acknowledged but never occupy a slot.
  assign store     = push && (in_addr != 5'd0);
  assign write_reg = rst && drain_en && !empty;
  assign pop       = write_reg;
  assign w_addr    = empty ? 5'd0 : addr_mem[head];
  assign w_data    = empty ? 32'd0 : data_mem[head];
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (store) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      unique case ({store, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match is the youngest.
  always_comb begin
    q_pending = 1'b0;
    q_data    = 32'd0;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < cnt) && (q_addr != 5'd0) &&
          (addr_mem[idx] == q_addr)) begin
        q_pending = 1'b1;
`ifdef WBQ_FORWARD_EN
        q_data    = data_mem[idx];
`else
        q_data    = 32'd0;
`endif
      end
    end
  end

endmodule
